// File: rtl/ps2_wasd_receiver_pkg.sv
// rtl/ps2_wasd_receiver_pkg.sv - scancodes, frame states and key lookup for the PS/2 WASD receiver
package ps2_wasd_receiver_pkg;

  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_state_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } key_hit_t;

  // Flag index: 0..3 = W/A/S/D, 4..7 = Up/Left/Down/Right
  function automatic key_hit_t map_key(input logic [7:0] code, input logic ext);
    key_hit_t k;
    k = '{hit: 1'b1, idx: 3'd0};
    if (!ext) begin
      case (code)
        SC_W:    k.idx = 3'd0;
        SC_A:    k.idx = 3'd1;
        SC_S:    k.idx = 3'd2;
        SC_D:    k.idx = 3'd3;
        default: k.hit = 1'b0;
      endcase
    end else begin
      case (code)
        SC_UP:    k.idx = 3'd4;
        SC_LEFT:  k.idx = 3'd5;
        SC_DOWN:  k.idx = 3'd6;
        SC_RIGHT: k.idx = 3'd7;
        default:  k.hit = 1'b0;
      endcase
    end
    return k;
  endfunction

endpackage

// File: rtl/ps2_wasd_receiver_frame_receiver.sv
// rtl/ps2_wasd_receiver_frame_receiver.sv - PS/2 synchroniser, clock glitch filter, frame FSM and timeout
module ps2_frame_receiver
  import ps2_wasd_receiver_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] scancode,
  output logic       frame_error
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          filt_clk;
  logic          filt_clk_q;
  logic [FW-1:0] filt_cnt;
  logic          fall_edge;

  frame_state_t  state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift, shift_n;
  logic          parity_bit, parity_bit_n;
  logic [TW-1:0] tmo_cnt, tmo_cnt_n;
  logic          byte_valid_n, frame_error_n;
  logic [7:0]    scancode_n;
  logic          sample;

  // Synchronisers and filter idle high so reset never fabricates an edge
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync   <= 2'b11;
      data_sync  <= 2'b11;
      filt_clk   <= 1'b1;
      filt_clk_q <= 1'b1;
      filt_cnt   <= '0;
    end else begin
      clk_sync   <= {clk_sync[0], ps2_clk};
      data_sync  <= {data_sync[0], ps2_data};
      filt_clk_q <= filt_clk;
      if (clk_sync[1] == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_clk <= clk_sync[1];
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fall_edge = filt_clk_q & ~filt_clk;
  assign sample    = data_sync[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      shift       <= '0;
      parity_bit  <= 1'b0;
      tmo_cnt     <= '0;
      byte_valid  <= 1'b0;
      frame_error <= 1'b0;
      scancode    <= '0;
    end else begin
      state       <= state_n;
      bit_cnt     <= bit_cnt_n;
      shift       <= shift_n;
      parity_bit  <= parity_bit_n;
      tmo_cnt     <= tmo_cnt_n;
      byte_valid  <= byte_valid_n;
      frame_error <= frame_error_n;
      scancode    <= scancode_n;
    end
  end

  always_comb begin
    state_n       = state;
    bit_cnt_n     = bit_cnt;
    shift_n       = shift;
    parity_bit_n  = parity_bit;
    tmo_cnt_n     = '0;
    byte_valid_n  = 1'b0;
    frame_error_n = 1'b0;
    scancode_n    = scancode;

    if (state != ST_IDLE && !fall_edge) tmo_cnt_n = tmo_cnt + 1'b1;

    case (state)
      ST_IDLE: begin
        if (fall_edge && !sample) begin
          state_n   = ST_DATA;
          bit_cnt_n = '0;
        end
      end
      ST_DATA: begin
        if (fall_edge) begin
          shift_n   = {sample, shift[7:1]};
          bit_cnt_n = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) state_n = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (fall_edge) begin
          parity_bit_n = sample;
          state_n      = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall_edge) begin
          state_n = ST_IDLE;
          if (sample && (^{shift, parity_bit})) begin
            byte_valid_n = 1'b1;
            scancode_n   = shift;
          end else begin
            frame_error_n = 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // A stalled keyboard abandons the partial frame
    if (state != ST_IDLE && !fall_edge && tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
      state_n       = ST_IDLE;
      tmo_cnt_n     = '0;
      frame_error_n = 1'b1;
    end
  end

endmodule

// File: rtl/ps2_wasd_receiver.sv
// rtl/ps2_wasd_receiver.sv - PS/2 keyboard to held w/a/s/d levels, WASD and arrow keys merged
module ps2_wasd_receiver
  import ps2_wasd_receiver_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       w,
  output logic       a,
  output logic       s,
  output logic       d,
  output logic       byte_valid,
  output logic [7:0] scancode,
  output logic       frame_error
);

  logic [7:0] pressed, pressed_n;
  logic       break_pending, break_pending_n;
  logic       ext_pending, ext_pending_n;
  key_hit_t   key;

  ps2_frame_receiver #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_frame (
    .clk         (clk),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .byte_valid  (byte_valid),
    .scancode    (scancode),
    .frame_error (frame_error)
  );

  assign key = map_key(scancode, ext_pending);

  always_comb begin
    pressed_n       = pressed;
    break_pending_n = break_pending;
    ext_pending_n   = ext_pending;
    if (frame_error) begin
      break_pending_n = 1'b0;
      ext_pending_n   = 1'b0;
    end else if (byte_valid) begin
      if (scancode == SC_BREAK) begin
        break_pending_n = 1'b1;
      end else if (scancode == SC_EXT) begin
        ext_pending_n = 1'b1;
      end else begin
        break_pending_n = 1'b0;
        ext_pending_n   = 1'b0;
        if (key.hit) pressed_n[key.idx] = ~break_pending;
      end
    end
  end

  // Outputs come from the next-state flags so they move one cycle after byte_valid
  always_ff @(posedge clk) begin
    if (reset) begin
      pressed       <= '0;
      break_pending <= 1'b0;
      ext_pending   <= 1'b0;
      w             <= 1'b0;
      a             <= 1'b0;
      s             <= 1'b0;
      d             <= 1'b0;
    end else begin
      pressed       <= pressed_n;
      break_pending <= break_pending_n;
      ext_pending   <= ext_pending_n;
      w             <= pressed_n[0] | pressed_n[4];
      a             <= pressed_n[1] | pressed_n[5];
      s             <= pressed_n[2] | pressed_n[6];
      d             <= pressed_n[3] | pressed_n[7];
    end
  end

endmodule

// File: tb/tb_ps2_wasd_receiver.sv
// tb/tb_ps2_wasd_receiver.sv - directed bench for ps2_wasd_receiver
module tb_ps2_wasd_receiver;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 2000;
  localparam int HALF       = 50;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       w, a, s, d;
  logic       byte_valid;
  logic [7:0] scancode;
  logic       frame_error;

  int n_checks = 0;
  int n_failures = 0;
  int bv_cnt = 0;
  int fe_cnt = 0;

  ps2_wasd_receiver #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .w           (w),
    .a           (a),
    .s           (s),
    .d           (d),
    .byte_valid  (byte_valid),
    .scancode    (scancode),
    .frame_error (frame_error)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (byte_valid)  bv_cnt++;
    if (frame_error) fe_cnt++;
  end

  task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_failures++;
      $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    wait_cycles(HALF / 2);
    ps2_data = b;
    if (glitch) begin
      wait_cycles(4);
      ps2_clk = 1'b0;
      wait_cycles(3);
      ps2_clk = 1'b1;
      wait_cycles(HALF / 2 - 7);
    end else begin
      wait_cycles(HALF / 2);
    end
    ps2_clk = 1'b0;
    wait_cycles(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input bit flip_par, input logic stop, input bit glitch);
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(code[i], glitch);
    send_bit((~^code) ^ flip_par, glitch);
    send_bit(stop, glitch);
    wait_cycles(HALF / 2);
    ps2_data = 1'b1;
    wait_cycles(2 * HALF);
  endtask

  task automatic send_byte(input logic [7:0] code);
    send_frame(code, 1'b0, 1'b1, 1'b0);
  endtask

  // Waits for byte_valid, then checks w on that cycle and the next
  task automatic watch_w(input string tag, input logic w_before, input logic w_after, input logic [7:0] exp_sc);
    int n;
    n = 0;
    while (!byte_valid && n < 30 * HALF) begin
      @(negedge clk);
      n++;
    end
    check_value({tag, "_bv_seen"}, 32'(byte_valid), 32'd1);
    check_value({tag, "_sc"}, 32'(scancode), 32'(exp_sc));
    check_value({tag, "_w_same_cycle"}, 32'(w), 32'(w_before));
    @(negedge clk);
    check_value({tag, "_w_next_cycle"}, 32'(w), 32'(w_after));
  endtask

  initial begin
    int bv0, fe0, n;

    wait_cycles(5);
    check_value("rst_keys", {28'd0, w, a, s, d}, 32'h0);
    check_value("rst_sc", 32'(scancode), 32'h00);
    check_value("rst_pulses", {30'd0, byte_valid, frame_error}, 32'h0);
    reset = 1'b0;
    wait_cycles(20);

    // 1: press and release W
    fork
      send_byte(8'h1D);
      watch_w("t1_make", 1'b0, 1'b1, 8'h1D);
    join
    send_byte(8'hF0);
    check_value("t1_w_after_f0", 32'(w), 32'd1);
    fork
      send_byte(8'h1D);
      watch_w("t1_break", 1'b1, 1'b0, 8'h1D);
    join
    check_value("t1_asd", {29'd0, a, s, d}, 32'h0);

    // 2: Up and W merged onto w, extended break
    send_byte(8'hE0);
    send_byte(8'h75);
    check_value("t2_up_make", 32'(w), 32'd1);
    send_byte(8'h1D);
    send_byte(8'hF0);
    send_byte(8'h1D);
    check_value("t2_w_rel_up_held", 32'(w), 32'd1);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    check_value("t2_up_rel", 32'(w), 32'd0);
    send_byte(8'h75);
    check_value("t2_plain75_unmapped", {28'd0, w, a, s, d}, 32'h0);

    // 3: parity and stop-bit errors
    bv0 = bv_cnt; fe0 = fe_cnt;
    send_frame(8'h23, 1'b1, 1'b1, 1'b0);
    check_value("t3_par_fe", 32'(fe_cnt - fe0), 32'd1);
    check_value("t3_par_bv", 32'(bv_cnt - bv0), 32'd0);
    check_value("t3_par_d", 32'(d), 32'd0);
    send_frame(8'h23, 1'b0, 1'b0, 1'b0);
    check_value("t3_stop_fe", 32'(fe_cnt - fe0), 32'd2);
    check_value("t3_stop_bv", 32'(bv_cnt - bv0), 32'd0);
    check_value("t3_stop_d", 32'(d), 32'd0);

    // 4: stalled partial frame times out
    fe0 = fe_cnt;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
    n = HALF;
    while (!frame_error && n < 3 * TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    check_value("t4_tmo_seen", 32'(frame_error), 32'd1);
    check_value("t4_tmo_window", 32'((n >= TIMEOUT) && (n <= TIMEOUT + 20)), 32'd1);
    wait_cycles(TIMEOUT + 500 - n);
    check_value("t4_single_fe", 32'(fe_cnt - fe0), 32'd1);
    send_byte(8'h1C);
    check_value("t4_a", 32'(a), 32'd1);

    // 5: glitches on ps2_clk
    bv0 = bv_cnt; fe0 = fe_cnt;
    for (int i = 0; i < 4; i++) begin
      ps2_clk = 1'b0;
      wait_cycles(3);
      ps2_clk = 1'b1;
      wait_cycles(30);
    end
    check_value("t5_idle_quiet", 32'((bv_cnt - bv0) + (fe_cnt - fe0)), 32'd0);
    send_frame(8'h1B, 1'b0, 1'b1, 1'b1);
    check_value("t5_one_byte", 32'(bv_cnt - bv0), 32'd1);
    check_value("t5_no_fe", 32'(fe_cnt - fe0), 32'd0);
    check_value("t5_sc", 32'(scancode), 32'h1B);
    check_value("t5_s", 32'(s), 32'd1);

    // 6: reset mid-frame
    send_byte(8'h23);
    check_value("t6_d_set", 32'(d), 32'd1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check_value("t6_rst_keys", {28'd0, w, a, s, d}, 32'h0);
    check_value("t6_rst_sc", 32'(scancode), 32'h00);
    reset = 1'b0;
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    ps2_data = 1'b1;
    bv0 = bv_cnt;
    wait_cycles(TIMEOUT + 500);
    check_value("t6_no_stale_byte", 32'(bv_cnt - bv0), 32'd0);
    check_value("t6_keys_clear", {28'd0, w, a, s, d}, 32'h0);
    send_byte(8'h1C);
    check_value("t6_sc", 32'(scancode), 32'h1C);
    check_value("t6_keys_a", {28'd0, w, a, s, d}, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_failures);
    $finish;
  end

endmodule
